// File: rtl/sobel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : sobel_pkg                                                         |
// | Brief   : Shared image-geometry defaults and counter-width helpers for the |
// |           Sobel pipeline.                                                   |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package sobel_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;

    // Width of a counter that must hold values 0..n-1, never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_COL_W = cnt_width(DEF_IMG_WIDTH);
    localparam int DEF_ROW_W = cnt_width(DEF_IMG_HEIGHT);

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : line_buffer                                                       |
// | Brief   : Single-clock simple dual-port RAM, combinational read,            |
// |           synchronous write. Holds one image row.                          |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 640,
    parameter int ADDR_W     = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Contents are never cleared; consumers mask stale data themselves.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/window_3x3_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : window_3x3_gen                                                    |
// | Brief   : Streaming 3x3 neighbourhood generator using two line buffers.    |
// |           Optional macro WINDOW_COORD_EN adds window-centre row_o/col_o.   |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module window_3x3_gen
    import sobel_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter  int IMG_HEIGHT = DEF_IMG_HEIGHT,
    localparam int COL_W      = cnt_width(IMG_WIDTH),
    localparam int ROW_W      = cnt_width(IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pixel_i,
    input  logic                  done_i,
    output logic [DATA_WIDTH-1:0] p00_o,
    output logic [DATA_WIDTH-1:0] p01_o,
    output logic [DATA_WIDTH-1:0] p02_o,
    output logic [DATA_WIDTH-1:0] p10_o,
    output logic [DATA_WIDTH-1:0] p11_o,
    output logic [DATA_WIDTH-1:0] p12_o,
    output logic [DATA_WIDTH-1:0] p20_o,
    output logic [DATA_WIDTH-1:0] p21_o,
    output logic [DATA_WIDTH-1:0] p22_o,
    output logic                  done_o,
    output logic                  frame_end_o
`ifdef WINDOW_COORD_EN
    ,
    output logic [ROW_W-1:0]      row_o,
    output logic [COL_W-1:0]      col_o
`endif
);

    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic [DATA_WIDTH-1:0] r_win [3][3];
    logic                  r_done;
    logic                  r_frame_end;

    logic [DATA_WIDTH-1:0] w_lb1_q;
    logic [DATA_WIDTH-1:0] w_lb2_q;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_win_ok;

    assign w_col_last = (r_col == COL_W'(IMG_WIDTH - 1));
    assign w_row_last = (r_row == ROW_W'(IMG_HEIGHT - 1));
    // Columns 0/1 hold leftovers from the previous row, rows 0/1 may hold stale RAM data.
    assign w_win_ok   = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

    line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .ADDR_W     (COL_W)
    ) u_lb1 (
        .clk   (clk),
        .we    (done_i),
        .waddr (r_col),
        .wdata (pixel_i),
        .raddr (r_col),
        .rdata (w_lb1_q)
    );

    // lb2 receives lb1's old content in the same cycle lb1 takes the new pixel.
    line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .ADDR_W     (COL_W)
    ) u_lb2 (
        .clk   (clk),
        .we    (done_i),
        .waddr (r_col),
        .wdata (w_lb1_q),
        .raddr (r_col),
        .rdata (w_lb2_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (done_i) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
            r_done      <= 1'b0;
            r_frame_end <= 1'b0;
        end else begin
            r_done      <= done_i && w_win_ok;
            r_frame_end <= done_i && w_row_last && w_col_last;
            if (done_i) begin
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= w_lb2_q;
                r_win[1][2] <= w_lb1_q;
                r_win[2][2] <= pixel_i;
            end
        end
    end

`ifdef WINDOW_COORD_EN
    logic [ROW_W-1:0] r_row_c;
    logic [COL_W-1:0] r_col_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row_c <= '0;
            r_col_c <= '0;
        end else if (done_i && w_win_ok) begin
            r_row_c <= r_row - ROW_W'(1);
            r_col_c <= r_col - COL_W'(1);
        end
    end

    assign row_o = r_row_c;
    assign col_o = r_col_c;
`endif

    assign p00_o       = r_win[0][0];
    assign p01_o       = r_win[0][1];
    assign p02_o       = r_win[0][2];
    assign p10_o       = r_win[1][0];
    assign p11_o       = r_win[1][1];
    assign p12_o       = r_win[1][2];
    assign p20_o       = r_win[2][0];
    assign p21_o       = r_win[2][1];
    assign p22_o       = r_win[2][2];
    assign done_o      = r_done;
    assign frame_end_o = r_frame_end;

endmodule
`default_nettype wire
